// File: rtl/time_set_controller_if.sv
// Button inputs and edit outputs of the time-set controller.
// The master side drives the buttons and the slave side is the controller.
interface time_set_controller_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [7:0] value_set_register;
    logic [1:0] value_set_selection;
    logic       set_active;

    modport master (
        output btn_mode, btn_inc, btn_dec,
        input  value_set_register, value_set_selection, set_active
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec,
        output value_set_register, value_set_selection, set_active
    );
endinterface

// File: rtl/time_set_controller.sv
// Time-set controller: synchronizes and debounces three buttons, auto-repeats
// inc/dec, and steps a packed-BCD edit value for the hour/minute/second fields.
module time_set_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    time_set_controller_if.slave bus
);

    localparam int unsigned NBTN     = 3;
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_INC  = 1;
    localparam int unsigned BTN_DEC  = 2;

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_MAX  = RP_W'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        RUN,
        SET_HOUR,
        SET_MIN,
        SET_SEC
    } state_e;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] deb_q, deb_d;
    logic [NBTN-1:0] deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [NBTN];
    logic [DB_W-1:0] db_cnt_d [NBTN];
    logic [RP_W-1:0] rep_cnt_q [2];
    logic [RP_W-1:0] rep_cnt_d [2];
    logic [1:0]      rep_fire;
    logic [NBTN-1:0] press;
    logic            mode_pulse, inc_pulse, dec_pulse;

    state_e     state_q, state_d;
    logic [7:0] value_q, value_d;
    logic [1:0] sel_q, sel_d;
    logic       active_q, active_d;

    assign btn_raw = {bus.btn_dec, bus.btn_inc, bus.btn_mode};

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)          return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                   return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)        return max;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                   return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [1:0] sel_code(input state_e s);
        case (s)
            SET_HOUR: return 2'b10;
            SET_MIN:  return 2'b01;
            SET_SEC:  return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < NBTN; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Repeat counter restarts at 1 after firing so the period stays REPEAT_CYCLES.
    always_comb begin
        for (int unsigned j = 0; j < 2; j++) begin
            rep_cnt_d[j] = '0;
            rep_fire[j]  = 1'b0;
            if (deb_q[j + 1]) begin
                if (rep_cnt_q[j] == RP_MAX) begin
                    rep_fire[j]  = 1'b1;
                    rep_cnt_d[j] = RP_W'(1);
                end else begin
                    rep_cnt_d[j] = rep_cnt_q[j] + RP_W'(1);
                end
            end
        end
    end

    assign press      = deb_q & ~deb_prev_q;
    assign mode_pulse = press[BTN_MODE];
    assign inc_pulse  = press[BTN_INC] | rep_fire[0];
    assign dec_pulse  = press[BTN_DEC] | rep_fire[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int unsigned i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
            for (int unsigned j = 0; j < 2; j++)    rep_cnt_q[j] <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int unsigned i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
            for (int unsigned j = 0; j < 2; j++)    rep_cnt_q[j] <= rep_cnt_d[j];
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        if (mode_pulse) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                default:  state_d = RUN;
            endcase
            value_d = '0;
        end else if (state_q != RUN && (inc_pulse ^ dec_pulse)) begin
            if (inc_pulse) value_d = bcd_inc(value_q, (state_q == SET_HOUR) ? 8'h23 : 8'h59);
            else           value_d = bcd_dec(value_q, (state_q == SET_HOUR) ? 8'h23 : 8'h59);
        end
        if (state_d == RUN) value_d = '0;
        sel_d    = sel_code(state_d);
        active_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            value_q  <= '0;
            sel_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            sel_q    <= sel_d;
            active_q <= active_d;
        end
    end

    assign bus.value_set_register  = value_q;
    assign bus.value_set_selection = sel_q;
    assign bus.set_active          = active_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short debounce/repeat settings.
module tb_time_set_controller;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    time_set_controller_if ifc ();

    time_set_controller #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] sel, input logic [7:0] val,
                           input logic act);
        chk({tag, ".sel"}, {6'd0, ifc.value_set_selection}, {6'd0, sel});
        chk({tag, ".val"}, ifc.value_set_register, val);
        chk({tag, ".act"}, {7'd0, ifc.set_active}, {7'd0, act});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i, input logic d, input int hold, input int gap);
        ifc.btn_mode = m;
        ifc.btn_inc  = i;
        ifc.btn_dec  = d;
        cyc(hold);
        ifc.btn_mode = 1'b0;
        ifc.btn_inc  = 1'b0;
        ifc.btn_dec  = 1'b0;
        cyc(gap);
    endtask

    task automatic mode_press();
        press(1'b1, 1'b0, 1'b0, 10, 8);
    endtask

    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1, 1'b0, 10, 8);
    endtask

    task automatic dec_n(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b0, 1'b1, 10, 8);
    endtask

    initial begin
        rst          = 1'b0;
        ifc.btn_mode = 1'b0;
        ifc.btn_inc  = 1'b0;
        ifc.btn_dec  = 1'b0;
        cyc(3);
        chk_out("reset", 2'b00, 8'h00, 1'b0);
        rst = 1'b1;
        cyc(2);

        // Mode cycling
        mode_press(); chk_out("mode_hour", 2'b10, 8'h00, 1'b1);
        mode_press(); chk_out("mode_min",  2'b01, 8'h00, 1'b1);
        mode_press(); chk_out("mode_sec",  2'b11, 8'h00, 1'b1);
        mode_press(); chk_out("mode_run",  2'b00, 8'h00, 1'b0);

        // Hours
        mode_press(); chk_out("hour_entry", 2'b10, 8'h00, 1'b1);
        inc_n(9);  chk("hour_09", ifc.value_set_register, 8'h09);
        inc_n(1);  chk("hour_10", ifc.value_set_register, 8'h10);
        inc_n(13); chk("hour_23", ifc.value_set_register, 8'h23);
        inc_n(1);  chk("hour_wrap_inc", ifc.value_set_register, 8'h00);
        dec_n(1);  chk("hour_wrap_dec", ifc.value_set_register, 8'h23);

        // Minutes
        mode_press(); chk_out("min_entry", 2'b01, 8'h00, 1'b1);
        dec_n(1);  chk("min_wrap_dec", ifc.value_set_register, 8'h59);
        inc_n(1);  chk("min_wrap_inc", ifc.value_set_register, 8'h00);
        inc_n(9);  chk("min_09", ifc.value_set_register, 8'h09);
        inc_n(1);  chk("min_10", ifc.value_set_register, 8'h10);
        dec_n(1);  chk("min_10_dec", ifc.value_set_register, 8'h09);
        inc_n(1);  chk("min_back_10", ifc.value_set_register, 8'h10);

        // Glitches shorter than the debounce window
        for (int k = 0; k < 6; k++) begin
            ifc.btn_inc = 1'b1; cyc(3);
            ifc.btn_inc = 1'b0; cyc(1);
        end
        cyc(10);
        chk("glitch", ifc.value_set_register, 8'h10);

        // Seconds: auto-repeat and simultaneous inc/dec
        mode_press(); chk_out("sec_entry", 2'b11, 8'h00, 1'b1);
        press(1'b0, 1'b1, 1'b0, 56, 12);
        chk("sec_repeat", ifc.value_set_register, 8'h04);
        press(1'b0, 1'b1, 1'b1, 10, 8);
        chk("sec_both", ifc.value_set_register, 8'h04);

        // Back to RUN; inc ignored there
        mode_press(); chk_out("run_again", 2'b00, 8'h00, 1'b0);
        inc_n(1);  chk_out("run_inc_ignored", 2'b00, 8'h00, 1'b0);

        mode_press();
        mode_press(); chk_out("min_again", 2'b01, 8'h00, 1'b1);
        inc_n(37); chk("min_37", ifc.value_set_register, 8'h37);

        // Asynchronous reset mid-edit, inc held across release
        rst = 1'b0;
        #1;
        chk_out("async_reset", 2'b00, 8'h00, 1'b0);
        ifc.btn_inc = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(8);
            chk_out("held_inc_run", 2'b00, 8'h00, 1'b0);
        end
        ifc.btn_inc = 1'b0;
        cyc(10);

        // Mode held across reset release needs a full debounce afterwards
        ifc.btn_mode = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(6);
        chk_out("mode_after_rst_early", 2'b00, 8'h00, 1'b0);
        cyc(4);
        chk_out("mode_after_rst_late", 2'b10, 8'h00, 1'b1);
        ifc.btn_mode = 1'b0;
        cyc(10);
        chk_out("mode_no_repeat", 2'b10, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable cycles required to accept a button level.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 12500000, meaning hold interval between auto-repeat steps of inc/dec.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port btn_mode  input  1  raw asynchronous push button, active-high; cycles the edit field.
REQ-006 SHALL have port btn_inc  input  1  raw asynchronous push button, active-high; increments the edited field.
REQ-007 SHALL have port btn_dec  input  1  raw asynchronous push button, active-high; decrements the edited field.
REQ-008 SHALL have port value_set_register  output  8  edited value, packed BCD: [7:4] tens, [3:0] units.
REQ-009 SHALL have port value_set_selection  output  2  field select: 00 run, 10 hours, 01 minutes, 11 seconds.
REQ-010 SHALL have port set_active  output  1  high whenever value_set_selection != 00.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-012 SHALL debounce each synchronized button independently: the debounced level takes the new value only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion clears that button's counter.
REQ-013 SHALL generate a one-cycle press pulse on each 0->1 transition of a debounced level.
REQ-014 SHALL generate additional inc/dec pulses while that debounced level stays high: the first after REPEAT_CYCLES of holding, then one every REPEAT_CYCLES; release stops repeat immediately.
REQ-015 SHALL implement FSM states RUN, SET_HOUR, SET_MIN, SET_SEC; each mode pulse advances RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-016 SHALL drive value_set_selection as 00/10/01/11 in RUN/SET_HOUR/SET_MIN/SET_SEC, registered, updated the cycle after the mode pulse.
REQ-017 SHALL load the edit value with 0x00 on every state transition and hold 0x00 in RUN.
REQ-018 SHALL in SET_HOUR step the edit value in BCD over 00..23: inc at 23 wraps to 00; dec at 00 wraps to 23; 09+1=10; 10-1=09.
REQ-019 SHALL in SET_MIN and SET_SEC step the edit value in BCD over 00..59: inc at 59 wraps to 00; dec at 00 wraps to 59.
REQ-020 SHALL never output a non-BCD nibble or an out-of-range value for the current field.
REQ-021 SHALL update value_set_register one cycle after the inc/dec pulse; one step per pulse.
REQ-022 SHALL ignore inc and dec pulses in RUN.
REQ-023 SHALL ignore an inc pulse and a dec pulse that occur in the same cycle (no change).
REQ-024 SHALL apply the mode pulse and ignore any inc/dec pulse when a mode pulse coincides with an inc/dec pulse in the same cycle.
REQ-025 SHALL not auto-repeat btn_mode.
REQ-026 SHALL drive all outputs directly from registers (no combinational paths from inputs).

Reset
REQ-027 SHALL, while rst is low, asynchronously force FSM to RUN, value_set_register=0x00, value_set_selection=00, set_active=0, and clear synchronizers, debounced levels, debounce counters and repeat counters.
REQ-028 SHALL, on reset assertion mid-edit or mid-debounce, discard the edit value and any pending pulse; a button held through reset release SHALL need a full DEBOUNCE_CYCLES before producing a pulse.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
REQ-029 SHALL cover: release rst, hold btn_mode for 10 cycles -> selection 00->10, value 0x00, set_active=1; three more presses -> 01, 11, 00.
REQ-030 SHALL cover: SET_HOUR, 23 inc presses -> value 0x23; one more -> 0x00; one dec -> 0x23.
REQ-031 SHALL cover: SET_MIN, dec once from 0x00 -> 0x59; inc -> 0x00; 10 inc -> 0x10 (nibbles never exceed 9).
REQ-032 SHALL cover: btn_inc glitches high for 3 cycles, low 1 cycle, repeatedly -> no change to value.
REQ-033 SHALL cover: SET_SEC, hold btn_inc for 4+2+16*3+2 cycles -> exactly 4 increments (0x04); btn_inc and btn_dec pressed together -> no change.
REQ-034 SHALL cover: in SET_MIN at 0x37, pulse rst low for 1 cycle -> selection 00, value 0x00 immediately; btn_inc held across reset release -> first pulse no earlier than 2+4 cycles after release, and ignored in RUN.
